reg_bank_master: RTL and testbench
==================================

Name: reg_bank_master

Overview:
- Bus initiator that drives the RegisterBank address/data_in/rw port from a valid/ready command stream.
- Returns one response per command on a valid/ready response stream.
- Sits between UVM-driven or firmware-model traffic and the register bank, replacing hand-sequenced pin wiggling.
- Registered outputs only; one outstanding command at a time.

Parameters:
- ADDR_W, 8, address width (matches bank address).
- DATA_W, 16, data width (matches bank data_in/data_out).
- READ_LATENCY, 1, bank cycles from address/rw=0 sampled to data_out valid; legal range 1..7.
- CNT_W, 16, width of transaction counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target register address.
- cmd_wdata  in  DATA_W  write data (ignored on read).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_write  out  1  echo of cmd_write.
- rsp_addr  out  ADDR_W  echo of cmd_addr.
- rsp_rdata  out  DATA_W  read data; 0 for writes (see Optional Feature).
- rsp_err  out  1  write-verify mismatch; 0 when feature absent.
- address  out  ADDR_W  to bank address.
- data_in  out  DATA_W  to bank data_in.
- rw  out  1  to bank rw (1 write, 0 read).
- data_out  in  DATA_W  from bank data_out.
- wr_count  out  CNT_W  completed writes, wraps at 2^CNT_W.
- rd_count  out  CNT_W  completed reads, wraps at 2^CNT_W.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (sync, takes effect at the edge where reset=1):
  - State IDLE; cmd_ready=0 during reset, 1 the cycle after release.
  - rsp_valid=0; rsp_* = 0.
  - address=0, data_in=0, rw=0; counters=0; busy=0.
- States:
  - IDLE:
    - cmd_ready=1, rw=0.
    - On the edge with cmd_valid&cmd_ready: latch cmd fields into address/data_in and echo registers.
    - If write: go WRITE, rw=1. If read: go READ, rw=0, wait counter = READ_LATENCY.
  - WRITE:
    - Exactly one cycle with rw=1 and address/data_in stable; bank commits at the next edge.
    - At that edge: rw=0, wr_count+1, rsp_rdata=0, rsp_err=0, go RESP (or VERIFY if feature enabled).
  - READ:
    - rw=0 and address held for READ_LATENCY+1 cycles.
    - On the last edge of that window: capture data_out into rsp_rdata, rd_count+1, go RESP.
  - RESP:
    - rsp_valid=1; all rsp_* held stable until rsp_valid&rsp_ready.
    - On that edge: rsp_valid=0, go IDLE.
    - cmd_ready=0 while in RESP; no command/response overlap.
- Latency from accept edge to rsp_valid high:
  - Write: 1 cycle.
  - Read: READ_LATENCY+1 cycles.
  - Min write throughput: one command per 3 cycles with rsp_ready tied high.
- address/data_in hold their last values in IDLE; rw is never 1 outside WRITE.
- cmd fields are sampled only at the accept edge; later cmd changes are ignored.
- rsp_ready held low: master stalls in RESP indefinitely; no command lost or reordered.
- Reset mid-operation: in-flight command and pending response discarded; counters cleared. An in-progress WRITE cycle is aborted (rw=0 after the reset edge).
- Counters wrap from 2^CNT_W-1 to 0 silently.
- READ_LATENCY outside 1..7: elaboration-time $error.

Optional Feature:
- Macro REG_BANK_MASTER_WRITE_VERIFY_EN.
- Defined:
  - After WRITE, enter VERIFY: rw=0, same address, READ_LATENCY+1 cycles.
  - Capture data_out into rsp_rdata; rsp_err = (readback != written data); then RESP.
  - Write latency becomes READ_LATENCY+2 cycles. rd_count is not incremented by verify reads.
- Undefined: no VERIFY state; rsp_err tied 0; write rsp_rdata = 0.

Test Plan:
1. Reset 2 cycles, release -> cycle after release: cmd_ready=1, rw=0, rsp_valid=0, counters 0, busy=0.
2. Write 0x01/0xABCD, then read 0x01, rsp_ready=1 -> one rw=1 cycle with address=0x01, data_in=0xABCD; write rsp_rdata=0x0000; read rsp_rdata=0xABCD at READ_LATENCY+1 cycles after accept; wr_count=1, rd_count=1.
3. Write 0x02/0x1234 with rsp_ready=0 for 5 cycles -> rsp_valid high and stable 5 cycles, cmd_ready=0 throughout; a read of 0x02 issued afterwards returns 0x1234.
4. Reset asserted during the WRITE cycle of 0x03/0x5555 -> rw=0 after the reset edge, no response, wr_count=0; a subsequent read of 0x03 returns the bank reset value (0x0000).
5. Back-to-back 2^CNT_W writes with CNT_W overridden to 4 -> wr_count reads 0 after the 16th write, 1 after the 17th.
6. With REG_BANK_MASTER_WRITE_VERIFY_EN, bank model forced to return 0xABCC on readback of 0x01 -> write response rsp_err=1, rsp_rdata=0xABCC; normal bank -> rsp_err=0, rsp_rdata=0xABCD, latency READ_LATENCY+2.

Source files
------------

// File: rtl/reg_bank_master.sv
// Valid/ready command-to-register-bank bus initiator with one outstanding transaction.
// Optional write read-back check enabled by defining REG_BANK_MASTER_WRITE_VERIFY_EN.
module reg_bank_master #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic              rw,
  input  logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count,
  output logic              busy
);

  if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
    $error("reg_bank_master: READ_LATENCY must be in 1..7");
  end

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StVerify, StResp} state_e;

  localparam logic [2:0] LatInit = 3'(READ_LATENCY);

  state_e     state_q;
  logic [2:0] wait_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      address   <= '0;
      data_in   <= '0;
      rw        <= 1'b0;
      wr_count  <= '0;
      rd_count  <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            address   <= cmd_addr;
            data_in   <= cmd_wdata;
            rsp_write <= cmd_write;
            rsp_addr  <= cmd_addr;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            wait_q    <= LatInit;
            if (cmd_write) begin
              rw      <= 1'b1;
              state_q <= StWrite;
            end else begin
              state_q <= StRead;
            end
          end
        end
        // The bank commits on this edge; rw drops so it is high for exactly one cycle.
        StWrite: begin
          rw        <= 1'b0;
          wr_count  <= wr_count + CNT_W'(1);
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
`ifdef REG_BANK_MASTER_WRITE_VERIFY_EN
          wait_q    <= LatInit;
          state_q   <= StVerify;
`else
          rsp_valid <= 1'b1;
          state_q   <= StResp;
`endif
        end
        StRead: begin
          if (wait_q == 3'd0) begin
            rsp_rdata <= data_out;
            rsp_err   <= 1'b0;
            rd_count  <= rd_count + CNT_W'(1);
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
`ifdef REG_BANK_MASTER_WRITE_VERIFY_EN
        // Read-back of the just-written word; not counted as a read.
        StVerify: begin
          if (wait_q == 3'd0) begin
            rsp_rdata <= data_out;
            rsp_err   <= (data_out != data_in);
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
`endif
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_master.sv
// Directed bench for reg_bank_master: bank model, transaction-level reference model,
// per-cycle compare process and literal pins taken from the vector table.
module tb_reg_bank_master;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int RL     = 2;
  localparam int CNT_W  = 4;
  localparam int CntMask = (1 << CNT_W) - 1;
`ifdef REG_BANK_MASTER_WRITE_VERIFY_EN
  localparam bit Verify = 1'b1;
  localparam int WrLat  = RL + 2;
`else
  localparam bit Verify = 1'b0;
  localparam int WrLat  = 1;
`endif

  logic              clk;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in, data_out;
  logic              rw, busy;
  logic [CNT_W-1:0]  wr_count, rd_count;

  reg_bank_master #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .READ_LATENCY(RL),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_addr (rsp_addr),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .address  (address),
    .data_in  (data_in),
    .rw       (rw),
    .data_out (data_out),
    .wr_count (wr_count),
    .rd_count (rd_count),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank: synchronous write, RL-cycle read pipeline, cleared by reset.
  logic [DATA_W-1:0] bank_mem [256];
  logic [DATA_W-1:0] pipe_d [RL];
  logic [ADDR_W-1:0] pipe_a [RL];
  logic              bank_corrupt;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) bank_mem[i] <= '0;
      for (int i = 0; i < RL; i++) begin
        pipe_d[i] <= '0;
        pipe_a[i] <= '0;
      end
    end else begin
      if (rw) bank_mem[address] <= data_in;
      pipe_d[0] <= bank_mem[address];
      pipe_a[0] <= address;
      for (int i = 1; i < RL; i++) begin
        pipe_d[i] <= pipe_d[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end
  assign data_out = (bank_corrupt && pipe_a[RL-1] == 8'h01) ? 16'hABCC : pipe_d[RL-1];

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
    int          stall;
    logic        corrupt;
    logic        abort;
    int          lit_rdata;
    int          lit_err;
    int          lit_wr;
    int          lit_rd;
  } vec_t;

  vec_t vecs [40];
  int   n_vecs;
  int   cur_vec;

  function automatic vec_t mk(logic wr, logic [7:0] a, logic [15:0] d, int stall, logic cor,
                              logic abort, int lr, int le, int lw, int lrd);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.stall = stall; v.corrupt = cor; v.abort = abort;
    v.lit_rdata = lr; v.lit_err = le; v.lit_wr = lw; v.lit_rd = lrd;
    return v;
  endfunction

  function automatic int lat_of(logic wr);
    return wr ? WrLat : RL + 1;
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: one transaction in flight, age counted in edges since accept.
  logic              m_busy, m_wr, started, rst_last, exp_valid;
  int                m_age, m_vec, m_wr_done, m_rd_done, lat;
  logic [ADDR_W-1:0] m_last_addr;
  logic [DATA_W-1:0] m_data, m_exp_rdata;
  logic              m_exp_err;
  logic [DATA_W-1:0] m_mem [256];

  initial begin
    started = 1'b0; rst_last = 1'b0; m_busy = 1'b0; m_wr = 1'b0; m_age = 0; m_vec = 0;
    m_wr_done = 0; m_rd_done = 0; m_last_addr = '0; m_data = '0; m_exp_rdata = '0;
    m_exp_err = 1'b0;
    forever begin
      @(negedge clk);
      exp_valid = 1'b0;
      lat = lat_of(m_wr);
      if (started && rst_last) begin
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rw", rw, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_fields", {rsp_write, rsp_err, rsp_addr, rsp_rdata}, 0);
        chk("rst_bank_port", {address, data_in}, 0);
        chk("rst_counters", {wr_count, rd_count}, 0);
        chk("rst_busy", busy, 0);
      end else if (started) begin
        exp_valid = m_busy && m_age >= lat;
        chk("cmd_ready", cmd_ready, !m_busy);
        chk("busy", busy, m_busy);
        chk("rw", rw, m_busy && m_wr && m_age == 0);
        chk("rsp_valid", rsp_valid, exp_valid);
        chk("address", address, m_last_addr);
        if (m_busy && m_wr && m_age == 0) chk("data_in", data_in, m_data);
        chk("wr_count", wr_count, (m_wr_done + ((m_busy && m_wr && m_age >= 1) ? 1 : 0)) & CntMask);
        chk("rd_count", rd_count, (m_rd_done + ((m_busy && !m_wr && m_age >= lat) ? 1 : 0)) & CntMask);
        if (exp_valid) begin
          chk("rsp_write", rsp_write, m_wr);
          chk("rsp_addr", rsp_addr, m_last_addr);
          chk("rsp_rdata", rsp_rdata, m_exp_rdata);
          chk("rsp_err", rsp_err, m_exp_err);
          if (m_age == lat && vecs[m_vec].lit_rdata >= 0)
            chk("lit_rdata", rsp_rdata, vecs[m_vec].lit_rdata);
          if (m_age == lat && vecs[m_vec].lit_err >= 0)
            chk("lit_err", rsp_err, vecs[m_vec].lit_err);
          if (rsp_ready && vecs[m_vec].lit_wr >= 0) chk("lit_wr_count", wr_count, vecs[m_vec].lit_wr);
          if (rsp_ready && vecs[m_vec].lit_rd >= 0) chk("lit_rd_count", rd_count, vecs[m_vec].lit_rd);
        end
      end
      // Advance the model to the state after the coming edge.
      if (reset) begin
        started = 1'b1; m_busy = 1'b0; m_wr_done = 0; m_rd_done = 0; m_last_addr = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
      end else if (started && !rst_last) begin
        if (m_busy) begin
          if (exp_valid && rsp_ready) begin
            m_busy = 1'b0;
            if (m_wr) m_wr_done++;
            else m_rd_done++;
          end else begin
            m_age++;
            if (m_age > lat + 40) begin
              n_vec++; n_err++;
              $display("FAIL response_timeout @%0t: no response after %0d cycles, expected %0d",
                       $time, m_age, lat);
              m_busy = 1'b0;
            end
          end
        end else if (cmd_valid) begin
          m_busy = 1'b1; m_age = 0; m_vec = cur_vec; m_wr = cmd_write;
          m_last_addr = cmd_addr; m_data = cmd_wdata;
          if (cmd_write) begin
            m_mem[cmd_addr] = cmd_wdata;
            m_exp_rdata = !Verify ? 16'h0000 :
                          (bank_corrupt && cmd_addr == 8'h01) ? 16'hABCC : cmd_wdata;
            m_exp_err = Verify && (m_exp_rdata != cmd_wdata);
          end else begin
            m_exp_rdata = m_mem[cmd_addr];
            m_exp_err = 1'b0;
          end
        end
      end
      rst_last = reset;
    end
  end

  task automatic run(input int i);
    int l;
    l = lat_of(vecs[i].wr);
    @(posedge clk); #1;
    cur_vec = i;
    bank_corrupt = vecs[i].corrupt;
    cmd_write = vecs[i].wr;
    cmd_addr = vecs[i].addr;
    cmd_wdata = vecs[i].data;
    rsp_ready = (vecs[i].stall == 0);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble the command after acceptance; the DUT must ignore it.
    cmd_valid = 1'b0;
    cmd_write = ~vecs[i].wr;
    cmd_addr = ~vecs[i].addr;
    cmd_wdata = ~vecs[i].data;
    if (vecs[i].abort) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end else begin
      if (vecs[i].stall > 0) begin
        repeat (l + vecs[i].stall) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
      for (int c = 0; c < 100 && m_busy; c++) @(posedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; bank_corrupt = 1'b0; cur_vec = 0; n_vecs = 0;
    vecs[n_vecs++] = mk(1, 8'h01, 16'hABCD, 0, 0, 0, Verify ? 32'hABCD : 0, 0, 1, 0);
    vecs[n_vecs++] = mk(0, 8'h01, 16'h0000, 0, 0, 0, 32'hABCD, 0, 1, 1);
    vecs[n_vecs++] = mk(1, 8'h02, 16'h1234, 5, 0, 0, -1, 0, 2, 1);
    vecs[n_vecs++] = mk(0, 8'h02, 16'h0000, 0, 0, 0, 32'h1234, 0, 2, 2);
    vecs[n_vecs++] = mk(1, 8'h03, 16'h5555, 0, 0, 1, -1, -1, -1, -1);
    vecs[n_vecs++] = mk(0, 8'h03, 16'h0000, 0, 0, 0, 32'h0000, 0, 0, 1);
    for (int k = 0; k < 17; k++)
      vecs[n_vecs++] = mk(1, 8'(8'h20 + k), 16'(16'h0100 + k), 0, 0, 0, -1, 0,
                          (k == 15) ? 0 : (k == 16) ? 1 : -1, 1);
`ifdef REG_BANK_MASTER_WRITE_VERIFY_EN
    vecs[n_vecs++] = mk(1, 8'h01, 16'hABCD, 0, 1, 0, 32'hABCC, 1, 2, 1);
    vecs[n_vecs++] = mk(1, 8'h01, 16'hABCD, 0, 0, 0, 32'hABCD, 0, 3, 1);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < n_vecs; i++) run(i);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout @%0t: bench did not finish, expected completion", $time);
    $fatal(1);
  end

endmodule
